// File: rtl/atconv_seq_ctrl.sv
// Sequencer for the atrous-conv engine: 3x3 dilated conv with replicate padding
// followed by 2x2 max-pool, driving memory addresses/strobes and datapath controls.
module atconv_seq_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DIL   = 2,
    parameter int AW    = 12
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          ready_i,
    output logic          busy_o,
    output logic [AW-1:0] iaddr_o,
    output logic          tap_valid_o,
    output logic [3:0]    tap_idx_o,
    output logic          acc_clr_o,
    output logic          crd_o,
    output logic [AW-1:0] caddr_rd_o,
    output logic          pool_valid_o,
    output logic          pool_first_o,
    output logic          cwr_o,
    output logic [AW-1:0] caddr_wr_o,
    output logic          csel_o
);

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int SW   = ((CW > RW) ? CW : RW) + 2;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int PQW  = AW - 2;

    localparam logic [AW-1:0]        LAST_PIX  = AW'(NPIX - 1);
    localparam logic [PQW-1:0]       LAST_POOL = PQW'(NPIX / 4 - 1);
    localparam logic signed [SW-1:0] DOFF      = SW'(DIL);
    localparam logic signed [SW-1:0] ROW_MAX   = SW'(IMG_H - 1);
    localparam logic signed [SW-1:0] COL_MAX   = SW'(IMG_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV_RD,
        CONV_WB,
        POOL_RD,
        POOL_WB
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  pix_q, pix_d;
    logic [3:0]     tap_q, tap_d;
    logic [PQW-1:0] pool_q, pool_d;
    logic [1:0]     sub_q, sub_d;

    logic          busy_q, busy_d;
    logic [AW-1:0] iaddr_q, iaddr_d;
    logic          tap_valid_q, tap_valid_d;
    logic [3:0]    tap_idx_q, tap_idx_d;
    logic          acc_clr_q, acc_clr_d;
    logic          crd_q, crd_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    logic          pool_first_q, pool_first_d;
    logic          cwr_q, cwr_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d;
    logic          csel_q, csel_d;

    // Signed row/col math so taps falling off the image clamp to the edge pixel.
    function automatic logic [AW-1:0] tapAddr(input logic [AW-1:0] pix, input logic [3:0] k);
        logic [1:0]           ky, kx;
        logic signed [SW-1:0] rowOff, colOff, row, col;
        ky     = 2'(k / 4'd3);
        kx     = 2'(k % 4'd3);
        rowOff = (ky == 2'd0) ? -DOFF : ((ky == 2'd2) ? DOFF : '0);
        colOff = (kx == 2'd0) ? -DOFF : ((kx == 2'd2) ? DOFF : '0);
        row    = $signed({{(SW-RW){1'b0}}, pix[AW-1:CW]}) + rowOff;
        col    = $signed({{(SW-CW){1'b0}}, pix[CW-1:0]}) + colOff;
        if (row < 0)       row = '0;
        if (row > ROW_MAX) row = ROW_MAX;
        if (col < 0)       col = '0;
        if (col > COL_MAX) col = COL_MAX;
        return {row[RW-1:0], col[CW-1:0]};
    endfunction

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        tap_d   = tap_q;
        pool_d  = pool_q;
        sub_d   = sub_q;
        case (state_q)
            IDLE: begin
                if (ready_i) begin
                    state_d = CONV_RD;
                    pix_d   = '0;
                    tap_d   = '0;
                end
            end
            CONV_RD: begin
                if (tap_q == 4'd8) state_d = CONV_WB;
                else               tap_d   = tap_q + 4'd1;
            end
            CONV_WB: begin
                tap_d = '0;
                if (pix_q == LAST_PIX) begin
                    state_d = POOL_RD;
                    pix_d   = '0;
                    pool_d  = '0;
                    sub_d   = '0;
                end else begin
                    state_d = CONV_RD;
                    pix_d   = pix_q + 1'b1;
                end
            end
            POOL_RD: begin
                if (sub_q == 2'd3) state_d = POOL_WB;
                else               sub_d   = sub_q + 2'd1;
            end
            POOL_WB: begin
                sub_d = '0;
                if (pool_q == LAST_POOL) begin
                    state_d = IDLE;
                    pool_d  = '0;
                end else begin
                    state_d = POOL_RD;
                    pool_d  = pool_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs describe the state being entered, so they land on the same edge as the transition.
        busy_d       = (state_d != IDLE);
        tap_valid_d  = (state_d == CONV_RD);
        tap_idx_d    = tap_valid_d ? tap_d : 4'd0;
        acc_clr_d    = tap_valid_d && (tap_d == 4'd0);
        iaddr_d      = tap_valid_d ? tapAddr(pix_d, tap_d) : iaddr_q;
        crd_d        = (state_d == POOL_RD);
        pool_first_d = crd_d && (sub_d == 2'd0);
        caddr_rd_d   = crd_d ? {pool_d[PQW-1:CW-1], sub_d[1], pool_d[CW-2:0], sub_d[0]} : caddr_rd_q;
        cwr_d        = (state_d == CONV_WB) || (state_d == POOL_WB);
        csel_d       = (state_d == POOL_WB);
        caddr_wr_d   = caddr_wr_q;
        if (state_d == CONV_WB)      caddr_wr_d = pix_d;
        else if (state_d == POOL_WB) caddr_wr_d = {2'b00, pool_d};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            pix_q        <= '0;
            tap_q        <= '0;
            pool_q       <= '0;
            sub_q        <= '0;
            busy_q       <= 1'b0;
            iaddr_q      <= '0;
            tap_valid_q  <= 1'b0;
            tap_idx_q    <= '0;
            acc_clr_q    <= 1'b0;
            crd_q        <= 1'b0;
            caddr_rd_q   <= '0;
            pool_first_q <= 1'b0;
            cwr_q        <= 1'b0;
            caddr_wr_q   <= '0;
            csel_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            tap_q        <= tap_d;
            pool_q       <= pool_d;
            sub_q        <= sub_d;
            busy_q       <= busy_d;
            iaddr_q      <= iaddr_d;
            tap_valid_q  <= tap_valid_d;
            tap_idx_q    <= tap_idx_d;
            acc_clr_q    <= acc_clr_d;
            crd_q        <= crd_d;
            caddr_rd_q   <= caddr_rd_d;
            pool_first_q <= pool_first_d;
            cwr_q        <= cwr_d;
            caddr_wr_q   <= caddr_wr_d;
            csel_q       <= csel_d;
        end
    end

    assign busy_o       = busy_q;
    assign iaddr_o      = iaddr_q;
    assign tap_valid_o  = tap_valid_q;
    assign tap_idx_o    = tap_idx_q;
    assign acc_clr_o    = acc_clr_q;
    assign crd_o        = crd_q;
    assign caddr_rd_o   = caddr_rd_q;
    assign pool_valid_o = crd_q;
    assign pool_first_o = pool_first_q;
    assign cwr_o        = cwr_q;
    assign caddr_wr_o   = caddr_wr_q;
    assign csel_o       = csel_q;

endmodule

// File: tb/tb_atconv_seq_ctrl.sv
// Bench for atconv_seq_ctrl: a run-index model predicts every output each cycle,
// with literal corner-pixel and pool checks pinning the model to known addresses.
module tb_atconv_seq_ctrl;

    localparam int AW      = 12;
    localparam int CONV_LEN = 64 * 64 * 10;
    localparam int RUN_LEN  = CONV_LEN + 1024 * 5;

    logic          clk;
    logic          resetN;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic          tapValid;
    logic [3:0]    tapIdx;
    logic          accClr;
    logic          crd;
    logic [AW-1:0] caddrRd;
    logic          poolValid;
    logic          poolFirst;
    logic          cwr;
    logic [AW-1:0] caddrWr;
    logic          csel;

    int testCount = 0;
    int failCount = 0;

    atconv_seq_ctrl dut (
        .clk_i        (clk),
        .reset_i      (resetN),
        .ready_i      (ready),
        .busy_o       (busy),
        .iaddr_o      (iaddr),
        .tap_valid_o  (tapValid),
        .tap_idx_o    (tapIdx),
        .acc_clr_o    (accClr),
        .crd_o        (crd),
        .caddr_rd_o   (caddrRd),
        .pool_valid_o (poolValid),
        .pool_first_o (poolFirst),
        .cwr_o        (cwr),
        .caddr_wr_o   (caddrWr),
        .csel_o       (csel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: whether a run is active and how many cycles into it we are.
    bit modelActive = 1'b0;
    int modelIdx    = 0;
    int modelDone   = 0;
    bit eBusy = 0, eTapValid = 0, eAccClr = 0, eCrd = 0, ePoolFirst = 0, eCwr = 0, eCsel = 0;
    int eTapIdx = 0, eIaddr = 0, eCaddrRd = 0, eCaddrWr = 0;

    function automatic int clampI(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Closed-form view of a run: 10 cycles per conv pixel, then 5 cycles per pooled pixel.
    task automatic modelEvent(input int idx);
        int p, ph, r, c, q, pr, pc;
        eBusy = 1; eTapValid = 0; eAccClr = 0; eCrd = 0; ePoolFirst = 0; eCwr = 0; eCsel = 0;
        if (idx < CONV_LEN) begin
            p = idx / 10; ph = idx % 10; r = p / 64; c = p % 64;
            if (ph < 9) begin
                eTapValid = 1;
                eTapIdx   = ph;
                eAccClr   = (ph == 0);
                eIaddr    = clampI(r + (ph / 3 - 1) * 2, 63) * 64 + clampI(c + (ph % 3 - 1) * 2, 63);
            end else begin
                eCwr     = 1;
                eCaddrWr = p;
            end
        end else begin
            q = (idx - CONV_LEN) / 5; ph = (idx - CONV_LEN) % 5; pr = q / 32; pc = q % 32;
            if (ph < 4) begin
                eCrd       = 1;
                ePoolFirst = (ph == 0);
                eCaddrRd   = (2 * pr + ph / 2) * 64 + 2 * pc + ph % 2;
            end else begin
                eCwr     = 1;
                eCsel    = 1;
                eCaddrWr = q;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!resetN) begin
            modelActive = 0; modelIdx = 0;
            eBusy = 0; eTapValid = 0; eAccClr = 0; eCrd = 0; ePoolFirst = 0; eCwr = 0; eCsel = 0;
            eTapIdx = 0; eIaddr = 0; eCaddrRd = 0; eCaddrWr = 0;
        end else begin
            if (modelActive) begin
                if (modelIdx == RUN_LEN - 1) begin
                    modelActive = 0;
                    modelDone++;
                end else begin
                    modelIdx++;
                end
            end else if (ready) begin
                modelActive = 1;
                modelIdx    = 0;
            end
            if (modelActive) modelEvent(modelIdx);
            else begin
                eBusy = 0; eTapValid = 0; eAccClr = 0; eCrd = 0; ePoolFirst = 0; eCwr = 0; eCsel = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    int px0[9]    = '{0, 0, 2, 0, 0, 2, 128, 128, 130};
    int px4095[9] = '{3965, 3967, 3967, 4093, 4095, 4095, 4093, 4095, 4095};
    int pool33[4] = '{130, 131, 194, 195};
    int busyRun   = 0;
    int doneSeen  = 0;

    // Single compare process: every output against the model, plus literal anchors.
    always @(negedge clk) begin
        checkOutput("busy", busy, eBusy);
        checkOutput("iaddr", iaddr, eIaddr);
        checkOutput("tap_valid", tapValid, eTapValid);
        if (eTapValid) checkOutput("tap_idx", tapIdx, eTapIdx);
        checkOutput("acc_clr", accClr, eAccClr);
        checkOutput("crd", crd, eCrd);
        checkOutput("caddr_rd", caddrRd, eCaddrRd);
        checkOutput("pool_valid", poolValid, eCrd);
        checkOutput("pool_first", poolFirst, ePoolFirst);
        checkOutput("cwr", cwr, eCwr);
        checkOutput("caddr_wr", caddrWr, eCaddrWr);
        checkOutput("csel", csel, eCsel);
        checkOutput("crd_cwr_excl", crd & cwr, 0);
        checkOutput("valid_excl", tapValid & poolValid, 0);
        if (modelActive) begin
            if (modelIdx == 0) begin
                checkOutput("start_acc_clr", accClr, 1);
                checkOutput("start_tap_idx", tapIdx, 0);
            end
            if (modelIdx < 9) checkOutput("px0_iaddr", iaddr, px0[modelIdx]);
            if (modelIdx == 9) begin
                checkOutput("px0_cwr", cwr, 1);
                checkOutput("px0_caddr_wr", caddrWr, 0);
                checkOutput("px0_csel", csel, 0);
            end
            if (modelIdx >= 40950 && modelIdx < 40959)
                checkOutput("px4095_iaddr", iaddr, px4095[modelIdx - 40950]);
            if (modelIdx == 40959) begin
                checkOutput("px4095_cwr", cwr, 1);
                checkOutput("px4095_caddr_wr", caddrWr, 4095);
            end
            if (modelIdx >= 41125 && modelIdx < 41129) begin
                checkOutput("q33_caddr_rd", caddrRd, pool33[modelIdx - 41125]);
                checkOutput("q33_pool_first", poolFirst, (modelIdx == 41125) ? 1 : 0);
            end
            if (modelIdx == 41129) begin
                checkOutput("q33_cwr", cwr, 1);
                checkOutput("q33_csel", csel, 1);
                checkOutput("q33_caddr_wr", caddrWr, 33);
            end
        end
        if (doneSeen != modelDone) begin
            checkOutput("run_length", busyRun, RUN_LEN);
            doneSeen = modelDone;
        end
        if (busy === 1'b1) busyRun++;
        else               busyRun = 0;
    end

    task automatic applyStimulus(input bit r, input bit rdy);
        resetN = r;
        ready  = rdy;
        @(negedge clk);
    endtask

    initial begin
        int n;
        // Reset held with ready high, then a full run with ready toggling randomly.
        repeat (3) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < RUN_LEN - 20; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
        // Ready held across the end of the run starts the next run back-to-back.
        repeat (40) applyStimulus(1'b1, 1'b1);
        n = $urandom_range(20, 3000);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        // Idle with ready low must stay idle, then a fresh start and another abort.
        n = $urandom_range(5, 30);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
        repeat (2) applyStimulus(1'b0, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
